// File: rtl/fifo_write_logic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_logic_pkg
// Description : Definitions shared by the async FIFO write/read control:
//               FSM state type and encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_write_logic_pkg;

    typedef logic [1:0] wstate_t;

    localparam wstate_t C_ST_IDLE  = 2'b00;  // nothing buffered
    localparam wstate_t C_ST_WRITE = 2'b01;  // partly filled, accepting writes
    localparam wstate_t C_ST_FULL  = 2'b10;  // no free slot; 2'b11 is illegal

endpackage : fifo_write_logic_pkg
`default_nettype wire

// File: rtl/fifo_write_logic_ptr_sync.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_logic_ptr_sync
// Description : Multi-flop synchroniser for a Gray-coded pointer crossing
//               into the local clock domain. Also used by the read side.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_logic_ptr_sync #(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] r_chain;

    // Shift the asynchronous pointer through STAGES flops; stage 0 is the
    // metastability catcher, the last stage is the usable output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chain <= '0;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], d};
        end
    end

    assign q = r_chain[STAGES-1];

endmodule : fifo_write_logic_ptr_sync
`default_nettype wire

// File: rtl/fifo_write_logic.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_logic
// Description : Write-domain control of the async FIFO. Accepts producer
//               writes, drives memory write enable/address, publishes a Gray
//               write pointer and derives full / almost-full / fill level /
//               overflow from the synchronised read pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_logic
    import fifo_write_logic_pkg::*;
#(
    parameter int ADDR_SZ      = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int AFULL_THRESH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               winc,
    input  logic [ADDR_SZ:0]   rptr_gray,
    output logic               wen,
    output logic [ADDR_SZ-1:0] waddr,
    output logic [ADDR_SZ:0]   wptr_gray,
    output logic               wfull,
    output logic               walmost_full,
    output logic [ADDR_SZ:0]   wcount,
    output logic               woverflow,
    output logic [1:0]         wstate
);

    localparam int              c_PW    = ADDR_SZ + 1;
    localparam logic [c_PW-1:0] c_AFULL = c_PW'(AFULL_THRESH);

    logic [c_PW-1:0] r_wbin;
    logic [c_PW-1:0] r_wgray;
    logic            r_wfull;
    logic            r_walmost_full;
    logic [c_PW-1:0] r_wcount;
    logic            r_woverflow;
    wstate_t         r_state;

    logic            w_accept;
    logic [c_PW-1:0] w_wbin_next;
    logic [c_PW-1:0] w_wgray_next;
    logic [c_PW-1:0] w_rq_gray;
    logic [c_PW-1:0] w_rq_bin;
    logic [c_PW-1:0] w_full_cmp;
    logic            w_wfull_next;
    logic [c_PW-1:0] w_fill_next;
    logic            w_afull_next;
    wstate_t         w_state_next;

    fifo_write_logic_ptr_sync #(
        .WIDTH  (c_PW),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk (clk),
        .rst (rst),
        .d   (rptr_gray),
        .q   (w_rq_gray)
    );

    // A write is taken only when not full; reset also masks the enable.
    assign w_accept     = winc & ~r_wfull;
    assign wen          = w_accept & ~rst;
    assign w_wbin_next  = r_wbin + {{ADDR_SZ{1'b0}}, w_accept};
    assign w_wgray_next = (w_wbin_next >> 1) ^ w_wbin_next;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_rq_bin = '0;
        for (int i = 0; i < c_PW; i++) begin
            w_rq_bin[i] = ^(w_rq_gray >> i);
        end
    end

    // Full when the write pointer is exactly one lap ahead of the read pointer:
    // in Gray form that is the top two bits inverted, the rest equal.
    if (ADDR_SZ == 1) begin : g_full_a1
        assign w_full_cmp = ~w_rq_gray;
    end else begin : g_full_an
        assign w_full_cmp = {~w_rq_gray[ADDR_SZ:ADDR_SZ-1], w_rq_gray[ADDR_SZ-2:0]};
    end

    assign w_wfull_next = (w_wgray_next == w_full_cmp);
    assign w_fill_next  = w_wbin_next - w_rq_bin;
    assign w_afull_next = (w_fill_next >= c_AFULL);

    // Pointer, flag and count registers, all updated from the same next values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wbin         <= '0;
            r_wgray        <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wcount       <= '0;
            r_woverflow    <= 1'b0;
        end else begin
            r_wbin         <= w_wbin_next;
            r_wgray        <= w_wgray_next;
            r_wfull        <= w_wfull_next;
            r_walmost_full <= w_afull_next;
            r_wcount       <= w_fill_next;
            r_woverflow    <= r_woverflow | (winc & r_wfull);
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state, driven by the same next fill/full values as the flags.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_ST_IDLE: begin
                if (w_wfull_next) begin
                    w_state_next = C_ST_FULL;
                end else if (w_fill_next != '0) begin
                    w_state_next = C_ST_WRITE;
                end
            end
            C_ST_WRITE: begin
                if (w_wfull_next) begin
                    w_state_next = C_ST_FULL;
                end else if (w_fill_next == '0) begin
                    w_state_next = C_ST_IDLE;
                end
            end
            C_ST_FULL: begin
                if (!w_wfull_next) begin
                    w_state_next = C_ST_WRITE;
                end
            end
            default: begin
                w_state_next = C_ST_IDLE;
            end
        endcase
    end

    // FSM and register outputs.
    always_comb begin
        wstate       = r_state;
        waddr        = r_wbin[ADDR_SZ-1:0];
        wptr_gray    = r_wgray;
        wfull        = r_wfull;
        walmost_full = r_walmost_full;
        wcount       = r_wcount;
        woverflow    = r_woverflow;
    end

endmodule : fifo_write_logic
`default_nettype wire

// File: tb/tb_fifo_write_logic.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_write_logic
// Description : Self-checking bench for fifo_write_logic: directed fill,
//               overflow, drain, reset and wrap sequences followed by random
//               write/read traffic against a fill-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_write_logic;

    localparam int ADDR_SZ      = 2;
    localparam int SYNC_STAGES  = 2;
    localparam int AFULL_THRESH = 3;
    localparam int DEPTH        = 1 << ADDR_SZ;
    localparam int MODW         = 2 * DEPTH;

    logic         clk = 1'b0;
    logic         rst;
    logic         winc;
    logic [2:0]   rptr_gray;
    logic         wen;
    logic [1:0]   waddr;
    logic [2:0]   wptr_gray;
    logic         wfull;
    logic         walmost_full;
    logic [2:0]   wcount;
    logic         woverflow;
    logic [1:0]   wstate;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b1;
    int rb_cur   = 0;

    // Reference model: total writes and read positions as plain integers.
    int m_wbin = 0;
    int m_fill = 0;
    bit m_full = 1'b0;
    bit m_afull = 1'b0;
    bit m_ovf = 1'b0;
    int m_rhist [SYNC_STAGES];

    fifo_write_logic #(
        .ADDR_SZ      (ADDR_SZ),
        .SYNC_STAGES  (SYNC_STAGES),
        .AFULL_THRESH (AFULL_THRESH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .winc         (winc),
        .rptr_gray    (rptr_gray),
        .wen          (wen),
        .waddr        (waddr),
        .wptr_gray    (wptr_gray),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wcount       (wcount),
        .woverflow    (woverflow),
        .wstate       (wstate)
    );

    always #5 clk = ~clk;

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    // Expected debug state follows directly from the fill level.
    function automatic int exp_state();
        if (m_full)      return 2;
        if (m_fill == 0) return 0;
        return 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic w, input logic r, input int rb);
        winc      = w;
        rst       = r;
        rb_cur    = rb;
        rptr_gray = 3'(to_gray(rb));
        @(posedge clk);
        #1;
    endtask

    // Model update at each active edge from the inputs the DUT also samples.
    always @(posedge clk) begin : model
        int acc;
        int wn;
        int rq;
        if (rst) begin
            m_wbin  = 0;
            m_fill  = 0;
            m_full  = 1'b0;
            m_afull = 1'b0;
            m_ovf   = 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) m_rhist[i] = 0;
        end else begin
            acc     = (winc && !m_full) ? 1 : 0;
            wn      = (m_wbin + acc) % MODW;
            rq      = m_rhist[SYNC_STAGES-1];
            m_fill  = (wn - rq + MODW) % MODW;
            if (winc && m_full) m_ovf = 1'b1;
            m_full  = (m_fill == DEPTH);
            m_afull = (m_fill >= AFULL_THRESH);
            m_wbin  = wn;
            for (int i = SYNC_STAGES - 1; i > 0; i--) m_rhist[i] = m_rhist[i-1];
            m_rhist[0] = rb_cur;
        end
    end

    // Compare every output against the model on the inactive edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("wen",          32'(wen),          32'(winc & ~m_full & ~rst));
            check("waddr",        32'(waddr),        32'(m_wbin % DEPTH));
            check("wptr_gray",    32'(wptr_gray),    32'(to_gray(m_wbin)));
            check("wfull",        32'(wfull),        32'(m_full));
            check("walmost_full", 32'(walmost_full), 32'(m_afull));
            check("wcount",       32'(wcount),       32'(m_fill));
            check("woverflow",    32'(woverflow),    32'(m_ovf));
            check("wstate",       32'(wstate),       32'(exp_state()));
        end
    end

    initial begin : stim
        int exp_g [4] = '{1, 3, 2, 6};
        int rb;
        logic [2:0] prev_g;
        for (int i = 0; i < SYNC_STAGES; i++) m_rhist[i] = 0;

        // Reset with winc held high.
        tick(1'b1, 1'b1, 0);
        tick(1'b1, 1'b1, 0);
        check("reset_wen",    32'(wen),          32'd0);
        check("reset_waddr",  32'(waddr),        32'd0);
        check("reset_wptr",   32'(wptr_gray),    32'd0);
        check("reset_wfull",  32'(wfull),        32'd0);
        check("reset_afull",  32'(walmost_full), 32'd0);
        check("reset_wcount", 32'(wcount),       32'd0);
        check("reset_ovf",    32'(woverflow),    32'd0);
        check("reset_state",  32'(wstate),       32'd0);

        // Fill four slots with the read pointer parked at zero.
        for (int k = 0; k < 4; k++) begin
            check("fill_waddr", 32'(waddr), 32'(k));
            tick(1'b1, 1'b0, 0);
            check("fill_wptr",   32'(wptr_gray),    32'(exp_g[k]));
            check("fill_wcount", 32'(wcount),       32'(k + 1));
            check("fill_afull",  32'(walmost_full), 32'(k >= 2));
            check("fill_wfull",  32'(wfull),        32'(k == 3));
        end

        // Keep writing while full: dropped and sticky overflow.
        check("ovf_wen", 32'(wen), 32'd0);
        tick(1'b1, 1'b0, 0);
        tick(1'b1, 1'b0, 0);
        check("ovf_flag",   32'(woverflow), 32'd1);
        check("ovf_waddr",  32'(waddr),     32'd0);
        check("ovf_wptr",   32'(wptr_gray), 32'd6);
        check("ovf_wcount", 32'(wcount),    32'd4);

        // One read: full clears SYNC_STAGES+1 cycles after the pointer moves.
        for (int c = 1; c <= SYNC_STAGES + 1; c++) begin
            tick(1'b0, 1'b0, 1);
            if (c <= SYNC_STAGES) begin
                check("drain_still_full", 32'(wfull), 32'd1);
            end else begin
                check("drain_wfull",  32'(wfull),  32'd0);
                check("drain_wcount", 32'(wcount), 32'd3);
                check("drain_state",  32'(wstate), 32'd1);
            end
        end
        check("drain_ovf_sticky", 32'(woverflow), 32'd1);

        // Reset with three entries buffered.
        tick(1'b0, 1'b1, 0);
        check("midrst_wcount", 32'(wcount),    32'd0);
        check("midrst_waddr",  32'(waddr),     32'd0);
        check("midrst_state",  32'(wstate),    32'd0);
        check("midrst_ovf",    32'(woverflow), 32'd0);
        tick(1'b0, 1'b0, 0);
        winc = 1'b1;
        #1;
        check("postrst_wen",   32'(wen),   32'd1);
        check("postrst_waddr", 32'(waddr), 32'd0);
        tick(1'b1, 1'b0, 0);
        check("postrst_wptr",  32'(wptr_gray), 32'd1);

        // Ten writes with the reader keeping up: pointer wraps, no false full.
        rb = 0;
        for (int i = 0; i < 10; i++) begin
            prev_g = wptr_gray;
            if (rb != m_wbin) rb = (rb + 1) % MODW;
            tick(1'b1, 1'b0, rb);
            check("wrap_gray_step", 32'($countones(wptr_gray ^ prev_g)), 32'd1);
            check("wrap_no_full",   32'(wfull), 32'd0);
        end
        check("wrap_waddr", 32'(waddr),     32'd3);
        check("wrap_wptr",  32'(wptr_gray), 32'd2);

        // Random traffic; the reader never overtakes the writer.
        for (int n = 0; n < 3000; n++) begin
            logic w;
            logic r;
            w = ($urandom_range(0, 9) < 7);
            r = ($urandom_range(0, 199) == 0);
            if (r) begin
                rb = 0;
            end else if (($urandom_range(0, 9) < 4) && (rb != m_wbin)) begin
                rb = (rb + 1) % MODW;
            end
            tick(w, r, rb);
        end

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fifo_write_logic
`default_nettype wire
